// File: rtl/class_score_accum_if.sv
// Handshake and score bus between the term producer, class_score_accum and the argmax consumer.
interface class_score_accum_if #(
   parameter int unsigned NUM_SIZE  = 26,
   parameter int unsigned TERM_SIZE = 16
);
   localparam int unsigned BUS_W = NUM_SIZE * 10;

   logic                 Start;
   logic                 InValid;
   logic                 InReady;
   logic [TERM_SIZE-1:0] InTerm;
   logic                 OutValid;
   logic                 OutReady;
   logic [BUS_W-1:0]     Num;
   logic                 Busy;
   logic                 Overflow;

   modport master (
      output Start, InValid, InTerm, OutReady,
      input  InReady, OutValid, Num, Busy, Overflow
   );

   modport slave (
      input  Start, InValid, InTerm, OutReady,
      output InReady, OutValid, Num, Busy, Overflow
   );
endinterface

// File: rtl/class_score_accum.sv
// Accumulates NUM_TERMS signed terms per class into ten packed NUM_SIZE-bit scores.
// Optional macro SCORE_SATURATE_EN: saturating additions with a sticky Overflow flag.
module class_score_accum #(
   parameter int unsigned NUM_SIZE  = 26,
   parameter int unsigned TERM_SIZE = 16,
   parameter int unsigned NUM_TERMS = 32,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               Clk,
   input  logic               GlobalReset,
   class_score_accum_if.slave bus
);
   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned CLS_W       = 4;
   localparam int unsigned BUS_W       = NUM_SIZE * NUM_CLASSES;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   state_e                      state_q, state_d;
   logic signed [NUM_SIZE-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]            term_cnt_q, term_cnt_d;
   logic [CLS_W-1:0]            class_cnt_q, class_cnt_d;
   logic [BUS_W-1:0]            num_q, num_d;
   logic                        ovf_q, ovf_d;

   logic signed [NUM_SIZE-1:0]  term_ext;
   logic signed [NUM_SIZE-1:0]  sum;
   logic                        clamp;

   assign term_ext = NUM_SIZE'(signed'(bus.InTerm));

`ifdef SCORE_SATURATE_EN
   localparam logic [NUM_SIZE-1:0] SAT_MAX = {1'b0, {(NUM_SIZE-1){1'b1}}};
   localparam logic [NUM_SIZE-1:0] SAT_MIN = {1'b1, {(NUM_SIZE-1){1'b0}}};
   logic signed [NUM_SIZE:0] sum_wide;

   // One guard bit: the two top bits disagree exactly when the true sum is out of range.
   assign sum_wide = (NUM_SIZE+1)'(acc_q) + (NUM_SIZE+1)'(term_ext);
   assign clamp    = sum_wide[NUM_SIZE] ^ sum_wide[NUM_SIZE-1];
   assign sum      = !clamp ? sum_wide[NUM_SIZE-1:0] :
                     (sum_wide[NUM_SIZE] ? SAT_MIN : SAT_MAX);
`else
   assign sum   = acc_q + term_ext;
   assign clamp = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (GlobalReset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         term_cnt_q  <= '0;
         class_cnt_q <= '0;
         num_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         term_cnt_q  <= term_cnt_d;
         class_cnt_q <= class_cnt_d;
         num_q       <= num_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      term_cnt_d  = term_cnt_q;
      class_cnt_d = class_cnt_q;
      num_d       = num_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d     = ACCUM;
               acc_d       = '0;
               term_cnt_d  = '0;
               class_cnt_d = '0;
               num_d       = '0;
               ovf_d       = 1'b0;
            end
         end
         ACCUM: begin
            if (bus.InValid) begin
               if (clamp) ovf_d = 1'b1;
               // Closing term writes the finished score straight into its slot.
               if (term_cnt_q == CNT_W'(NUM_TERMS - 1)) begin
                  num_d[NUM_SIZE*class_cnt_q +: NUM_SIZE] = sum;
                  acc_d       = '0;
                  term_cnt_d  = '0;
                  class_cnt_d = class_cnt_q + CLS_W'(1);
                  if (class_cnt_q == CLS_W'(NUM_CLASSES - 1)) state_d = DONE;
               end else begin
                  acc_d      = sum;
                  term_cnt_d = term_cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (bus.OutReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.InReady  = (state_q == ACCUM);
   assign bus.OutValid = (state_q == DONE);
   assign bus.Busy     = (state_q != IDLE);
   assign bus.Num      = num_q;
   assign bus.Overflow = ovf_q;
endmodule
